// File: rtl/instr_mem_responder_pkg.sv
// rtl/instr_mem_responder_pkg.sv - shared types and constants for the instruction memory responder
package instr_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } state_t;

  localparam int LINE_BYTES = 16;
  localparam int LINE_OFF_W = 4;
  localparam int INSTR_W    = 32;

endpackage

// File: rtl/instr_mem_array.sv
// rtl/instr_mem_array.sv - instruction backing store, one write port and one registered read port
module instr_mem_array
  import instr_mem_responder_pkg::*;
#(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic               rd_en,
  input  logic [AW-1:0]      rd_addr,
  output logic [INSTR_W-1:0] rd_data
);

  logic [INSTR_W-1:0] mem [WORDS];

  // Contents are deliberately outside the reset domain so a reset never loses the program.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read-first: a write on the same edge is seen by the next read, not this one.
  always_ff @(posedge CLK) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/instr_mem_responder.sv
// rtl/instr_mem_responder.sv - icache line-fill responder: fixed latency, then one word per beat
module instr_mem_responder
  import instr_mem_responder_pkg::*;
#(
  parameter int MEM_WORDS  = 1024,
  parameter int LINE_WORDS = 4,
  parameter int LATENCY    = 2
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [63:0]                  req_addr,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [INSTR_W-1:0]           resp_data,
  output logic                         resp_last,
  output logic                         resp_err,
  input  logic                         ld_en,
  input  logic [$clog2(MEM_WORDS)-1:0] ld_addr,
  input  logic [INSTR_W-1:0]           ld_data
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int BW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);
  localparam logic [3:0]    LAT_INIT  = 4'(LATENCY);

  state_t         state, state_n;
  logic [3:0]     lat_cnt, lat_n;
  logic [BW-1:0]  beat, beat_n, beat_inc;
  logic [AW-1:0]  line_word0, line_n, req_line0;
  logic           line_err, line_err_n, req_oob;
  logic           valid_n, last_n, err_n;
  logic           rd_en;
  logic [AW-1:0]  rd_addr;
  logic [INSTR_W-1:0] rd_word;

  // Only the in-range index bits are kept; the out-of-range condition is folded into line_err.
  assign req_line0 = AW'(req_addr >> 2) & ~AW'(LINE_WORDS - 1);
  assign req_oob   = |(req_addr >> (AW + 2));
  assign beat_inc  = beat + BW'(1);
  assign req_ready = (state == IDLE);

  always_comb begin
    state_n    = state;
    lat_n      = lat_cnt;
    beat_n     = beat;
    line_n     = line_word0;
    line_err_n = line_err;
    valid_n    = resp_valid;
    last_n     = resp_last;
    err_n      = resp_err;
    rd_en      = 1'b0;
    rd_addr    = line_word0 + AW'(beat);
    case (state)
      IDLE: begin
        if (req_valid) begin
          line_n     = req_line0;
          line_err_n = req_oob;
          beat_n     = '0;
          if (LATENCY == 0) begin
            state_n = BURST;
            rd_en   = 1'b1;
            rd_addr = req_line0;
            valid_n = 1'b1;
            last_n  = (LAST_BEAT == '0);
            err_n   = req_oob;
          end else begin
            state_n = WAIT;
            lat_n   = LAT_INIT;
          end
        end
      end
      WAIT: begin
        lat_n = lat_cnt - 4'd1;
        if (lat_cnt <= 4'd1) begin
          state_n = BURST;
          lat_n   = '0;
          rd_en   = 1'b1;
          rd_addr = line_word0;
          valid_n = 1'b1;
          last_n  = (LAST_BEAT == '0);
          err_n   = line_err;
        end
      end
      BURST: begin
        if (resp_valid && resp_ready) begin
          if (resp_last) begin
            state_n = IDLE;
            beat_n  = '0;
            valid_n = 1'b0;
            last_n  = 1'b0;
            err_n   = 1'b0;
          end else begin
            // Fetch the next word on the completing edge so beats run back to back.
            beat_n  = beat_inc;
            rd_en   = 1'b1;
            rd_addr = line_word0 + AW'(beat_inc);
            last_n  = (beat_inc == LAST_BEAT);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      beat       <= '0;
      line_word0 <= '0;
      line_err   <= 1'b0;
      resp_valid <= 1'b0;
      resp_last  <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_n;
      lat_cnt    <= lat_n;
      beat       <= beat_n;
      line_word0 <= line_n;
      line_err   <= line_err_n;
      resp_valid <= valid_n;
      resp_last  <= last_n;
      resp_err   <= err_n;
    end
  end

  instr_mem_array #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_array (
    .CLK     (CLK),
    .reset   (reset),
    .wr_en   (ld_en & ~reset),
    .wr_addr (ld_addr),
    .wr_data (ld_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_word)
  );

  assign resp_data = resp_err ? '0 : rd_word;

endmodule

// File: doc/instr_mem_responder.md
INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

Interface
REQ-001 Parameter MEM_WORDS, default 1024, backing store depth in 32-bit words; power of two, at least LINE_WORDS.
REQ-002 Parameter LINE_WORDS, default 4, words per cache line (16-byte line).
REQ-003 Parameter LATENCY, default 2, idle cycles between request acceptance and the first beat; range 0..15.
REQ-004 CLK  input  1  clock; all state changes on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  icache line-fill request present.
REQ-007 req_ready  output  1  responder can accept a request.
REQ-008 req_addr  input  64  byte address of the missing instruction.
REQ-009 resp_valid  output  1  resp_data holds a valid beat.
REQ-010 resp_ready  input  1  icache accepts the current beat.
REQ-011 resp_data  output  32  one instruction word, little-endian.
REQ-012 resp_last  output  1  current beat is the final word of the line.
REQ-013 resp_err  output  1  line lies outside the backing store.
REQ-014 ld_en  input  1  program-load write strobe.
REQ-015 ld_addr  input  log2(MEM_WORDS)  program-load word index.
REQ-016 ld_data  input  32  program-load write data.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, WAIT and BURST.
REQ-018 req_ready SHALL be 1 only in IDLE; a request is accepted on any cycle where req_valid and req_ready are both 1.
REQ-019 On acceptance, the block SHALL latch the line base req_addr[63:4] and clear the beat counter.
- If LATENCY>0: go to WAIT and load the latency counter.
- If LATENCY=0: go straight to BURST.
REQ-020 WAIT SHALL last exactly LATENCY cycles, then go to BURST; the first beat is valid LATENCY+1 cycles after acceptance.
REQ-021 Beats SHALL carry word indices base*LINE_WORDS+0 .. +LINE_WORDS-1 in ascending order; the requested word offset is ignored.
REQ-022 resp_data SHALL be registered when a beat is presented and held stable while resp_valid=1 and resp_ready=0.
REQ-023 A beat SHALL complete only when resp_valid and resp_ready are both 1; the next beat SHALL then be valid on the following cycle, with no bubble.
REQ-024 resp_last SHALL be 1 only on beat LINE_WORDS-1.
REQ-025 Completion of the last beat SHALL return the FSM to IDLE, with req_ready=1 on the next cycle.
REQ-026 If the byte address is at or above MEM_WORDS*4 (any of bits 63..log2(MEM_WORDS)+2 set):
- all LINE_WORDS beats are still issued;
- resp_data is 0 on every beat;
- resp_err is 1 on every beat.
REQ-027 resp_err SHALL be 0 on beats from an in-range line.
REQ-028 An ld_en write SHALL be honoured in any state and take effect at the clock edge.
REQ-029 A beat that is already presented SHALL NOT change because of a later load write.
REQ-030 A beat registered on the cycle after a load write SHALL return the written value.
REQ-031 A new request arriving during WAIT or BURST SHALL be stalled (req_ready=0), never dropped or merged.

Reset
REQ-032 While reset=1 at a clock edge, the next-cycle values SHALL be:
- FSM = IDLE, counters = 0;
- resp_valid, resp_last, resp_err = 0;
- resp_data = 0;
- req_ready = 1 from the first cycle after reset deasserts.
REQ-033 Reset asserted mid-WAIT or mid-BURST SHALL abort the line; no further beats of it are issued.
REQ-034 Reset SHALL NOT alter backing-store contents; ld_en is ignored during reset.

Structure
REQ-035 A shared package SHALL hold:
- the FSM state encoding;
- the line size in bytes (16) and the line offset width (4);
- the instruction width (32).
REQ-036 The backing store SHALL be one sub-module, instr_mem_array: single write port, single registered read port.
REQ-037 The FSM and counters SHALL live in instr_mem_responder.

Verification
REQ-038 Load words 0..3 with 0x00500093, 0x00108113, 0x002101B3, 0x00000073; request addr 0x8, LATENCY=2, resp_ready=1 -> beats 0x00500093, 0x00108113, 0x002101B3, 0x00000073 on cycles 3..6; resp_last only on cycle 6; resp_err=0.
REQ-039 Same line, resp_ready low for 3 cycles on beat 1 -> resp_data stays 0x00108113 throughout the stall; no bubble after it; req_ready returns the cycle after the last beat.
REQ-040 MEM_WORDS=1024, request addr 0x1000 -> 4 beats of 0x00000000 with resp_err=1 on all four.
REQ-041 req_valid held high during a burst with addr 0x10 -> the second request is accepted only after resp_last completes; it returns words 4..7 in order.
REQ-042 Reset asserted on beat 2 -> resp_valid=0 next cycle; req_ready=1 the cycle after reset deasserts; memory still returns 0x00500093 at word 0.
REQ-043 ld_en writes word 5 = 0xDEADBEEF while beat 1 of line 1 is stalled -> the stalled beat keeps its old value; beat 1 on a re-request of the same line returns 0xDEADBEEF.
